controle_partida: RTL and testbench

Parametrised game-flow controller for the werewolf board: runs night turns over `N_JOG` players, collects the wolves' night target, runs the day discussion and vote, and declares the winner. It owns the player counter, the alive mask and win detection internally, so no separate counter or elimination block is needed. It sits between the input-conditioning logic (one-cycle `passa`/`jogar` pulses, vote keypad) and the display/role datapath.

---
 rtl/controle_partida.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_controle_partida.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_partida.sv
// controle_partida -- game-flow controller for the werewolf board.
//
// Runs the night turns over N_JOG players and collects the wolves' night
// target. It then runs the day discussion and vote, and declares the winner.
// The player counter, the alive mask, the role map and the win detection
// all live inside this block.
//
// Optional feature: define the macro DISCUSSAO_TIMEOUT_EN to add a discussion
// timeout. With it, DIA_DISCUSSAO falls through to DIA_VOTO after T_DISC
// cycles even when no `passa` arrives. Without it, only `passa` leaves the
// discussion.
//
// Parameters
//   N_JOG   number of players (2..16)
//   LJ      player-index width
//   T_DISC  discussion timeout in cycles (only with DISCUSSAO_TIMEOUT_EN)
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   jogar               start/restart pulse (INICIAL and terminal states only)
//   passa               one-cycle advance pulse
//   mascara_lobos       role map, 1 = wolf, sampled in ARMAZENA_JOGO
//   alvo_noite_valido   wolf target strobe, alvo_noite = target index
//   votou, voto_alvo    vote present / voted player index
//   rst_global          datapath reset (INICIAL, RESETA_TUDO)
//   inc_seed            seed counter enable (PREPARA_JOGO)
//   e_seed_reg          seed register load (ARMAZENA_JOGO)
//   mostra_classe       show the current player's role (TURNO_NOITE)
//   processar_acao      current player's action window (TURNO_NOITE)
//   voto                vote window open (DIA_VOTO)
//   jogador_atual       current night player
//   vivos               alive mask
//   eliminado           last eliminated player
//   eliminado_valido    eliminado holds a death from the latest resolution
//   lobo_ganhou         wolves won
//   aldeia_ganhou       village won
//   db_estado           state code (31 when the state register is corrupted)
module controle_partida #(
  parameter int N_JOG  = 5,
  parameter int LJ     = $clog2(N_JOG),
  parameter int T_DISC = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             jogar,
  input  logic             passa,
  input  logic [N_JOG-1:0] mascara_lobos,
  input  logic             alvo_noite_valido,
  input  logic [LJ-1:0]    alvo_noite,
  input  logic             votou,
  input  logic [LJ-1:0]    voto_alvo,
  output logic             rst_global,
  output logic             inc_seed,
  output logic             e_seed_reg,
  output logic             mostra_classe,
  output logic             processar_acao,
  output logic             voto,
  output logic [LJ-1:0]    jogador_atual,
  output logic [N_JOG-1:0] vivos,
  output logic [LJ-1:0]    eliminado,
  output logic             eliminado_valido,
  output logic             lobo_ganhou,
  output logic             aldeia_ganhou,
  output logic [4:0]       db_estado
);

  typedef enum logic [4:0] {
    INICIAL          = 5'd0,
    RESETA_TUDO      = 5'd1,
    PREPARA_JOGO     = 5'd2,
    ARMAZENA_JOGO    = 5'd3,
    PREPARA_NOITE    = 5'd4,
    CHECAR_VIVO      = 5'd5,
    DELAY_NOITE      = 5'd6,
    TURNO_NOITE      = 5'd7,
    PROXIMO_JOGADOR  = 5'd8,
    FIM_NOITE        = 5'd9,
    AVALIAR_NOITE    = 5'd10,
    ANUNCIAR_MORTE   = 5'd11,
    CHECAR_FIM_NOITE = 5'd12,
    DIA_DISCUSSAO    = 5'd13,
    DIA_VOTO         = 5'd14,
    PROCESSA_VOTO    = 5'd15,
    CHECAR_FIM_DIA   = 5'd16,
    LOBO_GANHOU      = 5'd17,
    ALDEIA_GANHOU    = 5'd18
  } estado_t;

  estado_t          estado_r;
  estado_t          estado_prox_s;
  logic [N_JOG-1:0] vivos_r;
  logic [N_JOG-1:0] mask_r;
  logic [LJ-1:0]    jogador_r;
  logic [LJ-1:0]    alvo_r;
  logic             alvo_ok_r;
  logic [LJ-1:0]    voto_r;
  logic [LJ-1:0]    eliminado_r;
  logic             eliminado_valido_r;
  logic             rst_global_r;
  logic             inc_seed_r;
  logic             e_seed_reg_r;
  logic             turno_r;
  logic             voto_aberto_r;
  logic             lobo_ganhou_r;
  logic             aldeia_ganhou_r;

  logic             ultimo_s;
  logic             vivo_atual_s;
  logic             morte_noite_s;
  logic             voto_aceito_s;
  logic             aldeia_vence_s;
  logic             lobo_vence_s;
  logic             disc_fim_s;
  int unsigned      lv_s;
  int unsigned      av_s;

  // Number of set bits in a player mask.
  function automatic int unsigned popcount(input logic [N_JOG-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int k = 0; k < N_JOG; k++) begin
      n = n + 32'(v[k]);
    end
    return n;
  endfunction

  // Alive bit of player i. An index at or past N_JOG counts as not alive,
  // which is how out-of-range targets and votes are rejected.
  function automatic logic esta_vivo(input logic [N_JOG-1:0] v,
                                     input logic [LJ-1:0]    i);
    logic r;
    r = 1'b0;
    for (int k = 0; k < N_JOG; k++) begin
      if (32'(i) == 32'(k)) begin
        r = v[k];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // One-hot mask selecting player i. It is empty for an out-of-range index.
  function automatic logic [N_JOG-1:0] um_quente(input logic [LJ-1:0] i);
    logic [N_JOG-1:0] m;
    m = '0;
    for (int k = 0; k < N_JOG; k++) begin
      if (32'(i) == 32'(k)) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

  assign ultimo_s      = (32'(jogador_r) == 32'(N_JOG - 1));
  assign vivo_atual_s  = esta_vivo(vivos_r, jogador_r);
  assign morte_noite_s = alvo_ok_r && esta_vivo(vivos_r, alvo_r);
  assign voto_aceito_s = esta_vivo(vivos_r, voto_r);

  // Win check on the current alive mask; a village win takes priority.
  always_comb begin
    lv_s = popcount(vivos_r & mask_r);
    av_s = popcount(vivos_r & ~mask_r);
    if (lv_s == 32'd0) begin
      aldeia_vence_s = 1'b1;
      lobo_vence_s   = 1'b0;
    end else if (lv_s >= av_s) begin
      aldeia_vence_s = 1'b0;
      lobo_vence_s   = 1'b1;
    end else begin
      aldeia_vence_s = 1'b0;
      lobo_vence_s   = 1'b0;
    end
  end

`ifdef DISCUSSAO_TIMEOUT_EN
  localparam int LC = (T_DISC > 1) ? $clog2(T_DISC) : 1;
  logic [LC-1:0] disc_cnt_r;

  assign disc_fim_s = (32'(disc_cnt_r) == 32'(T_DISC - 1));

  // Discussion cycle counter. It stays at zero outside DIA_DISCUSSAO, so
  // every entry into the discussion starts a fresh count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disc_cnt_r <= '0;
    end else if (estado_r != DIA_DISCUSSAO) begin
      disc_cnt_r <= '0;
    end else if (!disc_fim_s) begin
      disc_cnt_r <= disc_cnt_r + LC'(1);
    end else begin
      disc_cnt_r <= disc_cnt_r;
    end
  end
`else
  assign disc_fim_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    estado_prox_s = estado_r;
    case (estado_r)
      INICIAL:          if (jogar) estado_prox_s = RESETA_TUDO;
                        else       estado_prox_s = INICIAL;
      RESETA_TUDO:      estado_prox_s = PREPARA_JOGO;
      PREPARA_JOGO:     if (passa) estado_prox_s = ARMAZENA_JOGO;
                        else       estado_prox_s = PREPARA_JOGO;
      ARMAZENA_JOGO:    estado_prox_s = PREPARA_NOITE;
      PREPARA_NOITE:    estado_prox_s = CHECAR_VIVO;
      CHECAR_VIVO: begin
        if (vivo_atual_s)  estado_prox_s = DELAY_NOITE;
        else if (ultimo_s) estado_prox_s = FIM_NOITE;
        else               estado_prox_s = PROXIMO_JOGADOR;
      end
      DELAY_NOITE:      if (passa) estado_prox_s = TURNO_NOITE;
                        else       estado_prox_s = DELAY_NOITE;
      TURNO_NOITE: begin
        if (!passa)        estado_prox_s = TURNO_NOITE;
        else if (ultimo_s) estado_prox_s = FIM_NOITE;
        else               estado_prox_s = PROXIMO_JOGADOR;
      end
      PROXIMO_JOGADOR:  estado_prox_s = CHECAR_VIVO;
      FIM_NOITE:        estado_prox_s = AVALIAR_NOITE;
      AVALIAR_NOITE:    estado_prox_s = ANUNCIAR_MORTE;
      ANUNCIAR_MORTE:   if (passa) estado_prox_s = CHECAR_FIM_NOITE;
                        else       estado_prox_s = ANUNCIAR_MORTE;
      CHECAR_FIM_NOITE: begin
        if (aldeia_vence_s)    estado_prox_s = ALDEIA_GANHOU;
        else if (lobo_vence_s) estado_prox_s = LOBO_GANHOU;
        else                   estado_prox_s = DIA_DISCUSSAO;
      end
      DIA_DISCUSSAO:    if (passa || disc_fim_s) estado_prox_s = DIA_VOTO;
                        else                     estado_prox_s = DIA_DISCUSSAO;
      DIA_VOTO:         if (passa && votou) estado_prox_s = PROCESSA_VOTO;
                        else                estado_prox_s = DIA_VOTO;
      PROCESSA_VOTO:    if (voto_aceito_s) estado_prox_s = CHECAR_FIM_DIA;
                        else               estado_prox_s = DIA_VOTO;
      CHECAR_FIM_DIA: begin
        if (aldeia_vence_s)    estado_prox_s = ALDEIA_GANHOU;
        else if (lobo_vence_s) estado_prox_s = LOBO_GANHOU;
        else                   estado_prox_s = PREPARA_NOITE;
      end
      LOBO_GANHOU:      if (jogar) estado_prox_s = RESETA_TUDO;
                        else       estado_prox_s = LOBO_GANHOU;
      ALDEIA_GANHOU:    if (jogar) estado_prox_s = RESETA_TUDO;
                        else       estado_prox_s = ALDEIA_GANHOU;
      default:          estado_prox_s = INICIAL;
    endcase
  end

  // State register, game datapath registers and Moore outputs.
  // The outputs are decoded from the next state, so each output is registered
  // and still valid in the same cycle its state is entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r           <= INICIAL;
      vivos_r            <= '1;
      mask_r             <= '0;
      jogador_r          <= '0;
      alvo_r             <= '0;
      alvo_ok_r          <= 1'b0;
      voto_r             <= '0;
      eliminado_r        <= '0;
      eliminado_valido_r <= 1'b0;
      rst_global_r       <= 1'b1;  // INICIAL keeps the datapath in reset
      inc_seed_r         <= 1'b0;
      e_seed_reg_r       <= 1'b0;
      turno_r            <= 1'b0;
      voto_aberto_r      <= 1'b0;
      lobo_ganhou_r      <= 1'b0;
      aldeia_ganhou_r    <= 1'b0;
    end else begin
      estado_r        <= estado_prox_s;
      rst_global_r    <= (estado_prox_s == INICIAL) || (estado_prox_s == RESETA_TUDO);
      inc_seed_r      <= (estado_prox_s == PREPARA_JOGO);
      e_seed_reg_r    <= (estado_prox_s == ARMAZENA_JOGO);
      turno_r         <= (estado_prox_s == TURNO_NOITE);
      voto_aberto_r   <= (estado_prox_s == DIA_VOTO);
      lobo_ganhou_r   <= (estado_prox_s == LOBO_GANHOU);
      aldeia_ganhou_r <= (estado_prox_s == ALDEIA_GANHOU);

      case (estado_r)
        RESETA_TUDO: begin
          vivos_r            <= '1;
          mask_r             <= '0;
          jogador_r          <= '0;
          alvo_ok_r          <= 1'b0;
          eliminado_valido_r <= 1'b0;
        end
        ARMAZENA_JOGO: begin
          mask_r <= mascara_lobos;
        end
        PREPARA_NOITE: begin
          jogador_r <= '0;
          alvo_ok_r <= 1'b0;
        end
        PROXIMO_JOGADOR: begin
          // The counter saturates at the last index.
          if (!ultimo_s) jogador_r <= jogador_r + LJ'(1);
          else           jogador_r <= jogador_r;
        end
        TURNO_NOITE: begin
          // Only a wolf's strobe counts. A later strobe replaces an earlier one.
          if (alvo_noite_valido && mask_r[jogador_r]) begin
            alvo_r    <= alvo_noite;
            alvo_ok_r <= 1'b1;
          end else begin
            alvo_r    <= alvo_r;
            alvo_ok_r <= alvo_ok_r;
          end
        end
        AVALIAR_NOITE: begin
          if (morte_noite_s) begin
            vivos_r            <= vivos_r & ~um_quente(alvo_r);
            eliminado_r        <= alvo_r;
            eliminado_valido_r <= 1'b1;
          end else begin
            eliminado_valido_r <= 1'b0;
          end
        end
        DIA_VOTO: begin
          if (passa && votou) voto_r <= voto_alvo;
          else                voto_r <= voto_r;
        end
        PROCESSA_VOTO: begin
          if (voto_aceito_s) begin
            vivos_r            <= vivos_r & ~um_quente(voto_r);
            eliminado_r        <= voto_r;
            eliminado_valido_r <= 1'b1;
          end else begin
            eliminado_valido_r <= 1'b0;
          end
        end
        default: begin
          vivos_r <= vivos_r;
        end
      endcase
    end
  end

  assign rst_global       = rst_global_r;
  assign inc_seed         = inc_seed_r;
  assign e_seed_reg       = e_seed_reg_r;
  assign mostra_classe    = turno_r;
  assign processar_acao   = turno_r;
  assign voto             = voto_aberto_r;
  assign jogador_atual    = jogador_r;
  assign vivos            = vivos_r;
  assign eliminado        = eliminado_r;
  assign eliminado_valido = eliminado_valido_r;
  assign lobo_ganhou      = lobo_ganhou_r;
  assign aldeia_ganhou    = aldeia_ganhou_r;
  // A code past ALDEIA_GANHOU can only come from corruption, so it reads 31.
  assign db_estado        = (estado_r <= ALDEIA_GANHOU) ? 5'(estado_r) : 5'd31;

endmodule

// File: tb/tb_controle_partida.sv
`timescale 1ns/1ps
module tb_controle_partida;
  localparam int N  = 5;
  localparam int LJ = 3;
  localparam int TD = 8;

  logic          clock = 1'b0;
  logic          reset, jogar, passa, alvo_noite_valido, votou;
  logic [N-1:0]  mascara_lobos;
  logic [LJ-1:0] alvo_noite, voto_alvo;
  logic          rst_global, inc_seed, e_seed_reg, mostra_classe, processar_acao, voto;
  logic [LJ-1:0] jogador_atual, eliminado;
  logic [N-1:0]  vivos;
  logic          eliminado_valido, lobo_ganhou, aldeia_ganhou;
  logic [4:0]    db_estado;

  int checks   = 0;
  int failures = 0;
  int alive[N];
  int wolf[N];
  int nt_q[$];
  int vt_q[$];
  int ab;

  always #5 clock = ~clock;

  controle_partida #(.N_JOG(N), .LJ(LJ), .T_DISC(TD)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .passa(passa),
    .mascara_lobos(mascara_lobos), .alvo_noite_valido(alvo_noite_valido),
    .alvo_noite(alvo_noite), .votou(votou), .voto_alvo(voto_alvo),
    .rst_global(rst_global), .inc_seed(inc_seed), .e_seed_reg(e_seed_reg),
    .mostra_classe(mostra_classe), .processar_acao(processar_acao), .voto(voto),
    .jogador_atual(jogador_atual), .vivos(vivos), .eliminado(eliminado),
    .eliminado_valido(eliminado_valido), .lobo_ganhou(lobo_ganhou),
    .aldeia_ganhou(aldeia_ganhou), .db_estado(db_estado)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_passa();
    passa = 1'b1;
    tick();
    passa = 1'b0;
  endtask

  // Reference model: plain arrays of alive players and roles.
  function automatic logic [N-1:0] alive_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (alive[i] != 0);
    return v;
  endfunction

  function automatic int count_alive(input int want_wolf);
    int n = 0;
    for (int i = 0; i < N; i++) if (alive[i] != 0 && wolf[i] == want_wolf) n++;
    return n;
  endfunction

  // Game outcome after a check state: village if no wolf lives, wolves if they
  // are at least as many as the villagers, otherwise the game continues.
  function automatic int outcome(input int cont);
    if (count_alive(1) == 0) return 18;
    if (count_alive(1) >= count_alive(0)) return 17;
    return cont;
  endfunction

  function automatic int enc(input int q[$]);
    int e = 1;
    foreach (q[k]) e = e * 16 + q[k];
    return e;
  endfunction

  function automatic int pick_alive();
    int s = int'($urandom_range(0, N - 1));
    for (int k = 0; k < N; k++) if (alive[(s + k) % N] != 0) return (s + k) % N;
    return 0;
  endfunction

  task automatic wait_night(output int st);
    st = -1;
    for (int k = 0; k < 20; k++) begin
      if (db_estado == 5'd6 || db_estado == 5'd9) begin
        st = int'(db_estado);
        break;
      end
      tick();
    end
    if (st < 0) chk("night_wait_timeout", 32'(db_estado), 32'd9);
  endtask

  task automatic play_game(input logic [N-1:0] m, input int abort_night, output int aborted);
    int res, st, target, p, t, v, n, night_no, exp_ev, accepted, a, first, use_dir, dt, wp;
    int visited[$];
    int expq[$];
    aborted  = 0;
    night_no = 0;
    jogar = 1'b1; tick(); jogar = 1'b0;
    chk("reseta_tudo", 32'(db_estado), 32'd1);
    chk("rst_global_reseta", 32'(rst_global), 32'd1);
    tick();
    chk("prepara_jogo", 32'(db_estado), 32'd2);
    chk("inc_seed", 32'(inc_seed), 32'd1);
    chk("vivos_inicio", 32'(vivos), 32'h1f);
    chk("ev_inicio", 32'(eliminado_valido), 32'd0);
    jogar = 1'b1; tick(); jogar = 1'b0;
    chk("jogar_ignorado", 32'(db_estado), 32'd2);
    mascara_lobos = m;
    pulse_passa();
    chk("armazena", 32'(db_estado), 32'd3);
    chk("e_seed_reg", 32'(e_seed_reg), 32'd1);
    for (int i = 0; i < N; i++) begin
      alive[i] = 1;
      wolf[i]  = int'(m[i]);
    end
    tick();
    chk("prepara_noite", 32'(db_estado), 32'd4);
    res = 4;
    while (res == 4 && night_no < 10) begin
      night_no++;
      expq.delete();
      visited.delete();
      for (int i = 0; i < N; i++) if (alive[i] != 0) expq.push_back(i);
      target  = -1;
      use_dir = (nt_q.size() > 0) ? 1 : 0;
      dt      = (use_dir != 0) ? nt_q.pop_front() : 0;
      first   = 1;
      st      = 0;
      while (st != 9 && st != -1) begin
        wait_night(st);
        if (st == 6) begin
          p = int'(jogador_atual);
          visited.push_back(p);
          pulse_passa();
          chk("turno_noite", 32'(db_estado), 32'd7);
          chk("turno_sinais", 32'({mostra_classe, processar_acao}), 32'd3);
          if (abort_night == night_no) begin
            reset = 1'b1;
            #1;
            chk("abort_estado", 32'(db_estado), 32'd0);
            chk("abort_vivos", 32'(vivos), 32'h1f);
            chk("abort_jogador", 32'(jogador_atual), 32'd0);
            chk("abort_ev", 32'(eliminado_valido), 32'd0);
            chk("abort_eliminado", 32'(eliminado), 32'd0);
            tick();
            reset = 1'b0;
            tick();
            aborted = 1;
            return;
          end
          if (use_dir != 0) begin
            t = first ? dt : -1;
          end else begin
            t = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
          end
          first = 0;
          wp = int'($urandom_range(0, 1));
          if (t >= 0) begin
            alvo_noite_valido = 1'b1;
            alvo_noite = 3'(t);
            if (wolf[p] != 0) target = t;
            passa = (wp != 0);
            tick();
            alvo_noite_valido = 1'b0;
            passa = 1'b0;
            if (wp == 0) pulse_passa();
          end else begin
            pulse_passa();
          end
        end
      end
      if (st == -1) return;
      chk("visitas", 32'(enc(visited)), 32'(enc(expq)));
      exp_ev = 0;
      if (target >= 0 && target < N) begin
        if (alive[target] != 0) begin
          alive[target] = 0;
          exp_ev = 1;
        end
      end
      tick();
      chk("avaliar_noite", 32'(db_estado), 32'd10);
      tick();
      chk("anunciar_morte", 32'(db_estado), 32'd11);
      chk("noite_vivos", 32'(vivos), 32'(alive_vec()));
      chk("noite_ev", 32'(eliminado_valido), 32'(exp_ev));
      if (exp_ev != 0) chk("noite_eliminado", 32'(eliminado), 32'(target));
      pulse_passa();
      chk("checar_fim_noite", 32'(db_estado), 32'd12);
      tick();
      res = outcome(13);
      chk("pos_noite", 32'(db_estado), 32'(res));
      if (res == 13) begin
`ifdef DISCUSSAO_TIMEOUT_EN
        n = 0;
        while (db_estado == 5'd13 && n < TD + 4) begin
          tick();
          n++;
        end
        chk("timeout_ciclos", 32'(n), 32'(TD));
`else
        pulse_passa();
`endif
        chk("dia_voto", 32'(db_estado), 32'd14);
        chk("voto_aberto", 32'(voto), 32'd1);
        accepted = 0;
        a = 0;
        res = -1;
        while (accepted == 0 && a < 12) begin
          if (vt_q.size() > 0)  v = vt_q.pop_front();
          else if (a >= 3)      v = pick_alive();
          else                  v = int'($urandom_range(0, 7));
          a++;
          votou = 1'b1; voto_alvo = 3'(v); passa = 1'b1;
          tick();
          votou = 1'b0; passa = 1'b0;
          chk("processa_voto", 32'(db_estado), 32'd15);
          tick();
          if (v < N && alive[v] != 0) begin
            alive[v] = 0;
            accepted = 1;
            chk("checar_fim_dia", 32'(db_estado), 32'd16);
            chk("voto_vivos", 32'(vivos), 32'(alive_vec()));
            chk("voto_ev", 32'(eliminado_valido), 32'd1);
            chk("voto_eliminado", 32'(eliminado), 32'(v));
            tick();
            res = outcome(4);
            chk("pos_dia", 32'(db_estado), 32'(res));
          end else begin
            chk("voto_recusado", 32'(db_estado), 32'd14);
            chk("recusado_ev", 32'(eliminado_valido), 32'd0);
            chk("recusado_vivos", 32'(vivos), 32'(alive_vec()));
          end
        end
      end
    end
    if (res == 17 || res == 18) begin
      chk("lobo_ganhou", 32'(lobo_ganhou), 32'(res == 17));
      chk("aldeia_ganhou", 32'(aldeia_ganhou), 32'(res == 18));
    end
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; passa = 1'b0; votou = 1'b0;
    alvo_noite_valido = 1'b0; alvo_noite = '0; voto_alvo = '0; mascara_lobos = '0;
    tick(); tick();
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_vivos", 32'(vivos), 32'h1f);
    chk("rst_jogador", 32'(jogador_atual), 32'd0);
    chk("rst_eliminado", 32'(eliminado), 32'd0);
    chk("rst_ev", 32'(eliminado_valido), 32'd0);
    chk("rst_strobes", 32'({inc_seed, e_seed_reg, mostra_classe, processar_acao, voto,
                             lobo_ganhou, aldeia_ganhou}), 32'd0);
    reset = 1'b0;
    tick();
    chk("inicial", 32'(db_estado), 32'd0);
    chk("inicial_rst_global", 32'(rst_global), 32'd1);

    // Wolf 0 kills 3, village votes out the wolf.
    nt_q = {3}; vt_q = {0};
    play_game(5'b00001, 0, ab);
    chk("jogo_a_final", 32'(db_estado), 32'd18);

    // Two wolves: first night kill 2 leaves wolves level with villagers.
    nt_q = {2}; vt_q = {};
    play_game(5'b00011, 0, ab);
    chk("jogo_b_final", 32'(db_estado), 32'd17);

    // Non-wolf strobe ignored; out-of-range vote refused; wolf voted out.
    nt_q = {3}; vt_q = {7, 1};
    play_game(5'b00010, 0, ab);
    chk("jogo_c_final", 32'(db_estado), 32'd18);

    // Kill 2, vote for the dead player is refused, then random continuation.
    nt_q = {2}; vt_q = {2, 3};
    play_game(5'b00001, 0, ab);

    // Reset in the second night's first turn.
    nt_q = {3}; vt_q = {4};
    play_game(5'b00001, 2, ab);
    chk("jogo_e_abortado", 32'(ab), 32'd1);

    for (int g = 0; g < 8; g++) begin
      nt_q = {}; vt_q = {};
      play_game(5'($urandom_range(1, 31)), 0, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
